// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: bus word, RAM handshake state and the
// arbiter state encoding that coherence and system benches can probe.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Raw encodings for the arbiter state register.
    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the RAM arbiter.
// master = the arbiter, slave = caches plus RAM model.
interface ram_arbiter_if #(
    parameter int REQS = 4,
    parameter int ID_W = $clog2(REQS)
);
    import cpu_types_pkg::*;

    logic [REQS-1:0]  req_ren;
    logic [REQS-1:0]  req_wen;
    logic [REQS-1:0]  req_lock;
    word_t [REQS-1:0] req_addr;
    word_t [REQS-1:0] req_store;
    logic [REQS-1:0]  req_wait;
    word_t [REQS-1:0] req_load;

    logic             ramREN;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    ramstate_t        ramstate;
    word_t            ramload;

    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             ram_err;

    modport master (
        input  req_ren, req_wen, req_lock, req_addr, req_store, ramstate, ramload,
        output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
               grant_valid, grant_id, ram_err
    );

    modport slave (
        output req_ren, req_wen, req_lock, req_addr, req_store, ramstate, ramload,
        input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore,
               grant_valid, grant_id, ram_err
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then map that offset back to a requester index.
module rr_picker #(
    parameter int REQS = 4,
    parameter int ID_W = $clog2(REQS)
) (
    input  logic [REQS-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o
);

    logic [2*REQS-1:0] dbl;
    logic [REQS-1:0]   rot;

    assign dbl = {req_i, req_i};
    assign rot = dbl[ptr_i +: REQS];

    always_comb begin
        int s;
        s       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        // Descending scan so the smallest offset from ptr_i is the last to win.
        for (int i = REQS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                s = int'(ptr_i) + i;
                if (s >= REQS) s = s - REQS;
                found_o = 1'b1;
                idx_o   = ID_W'(s);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single RAM port shared by the I/D caches.
// Grants one requester at a time, with optional locked bursts capped at MAX_BEATS.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int REQS      = 4,
    parameter int MAX_BEATS = 2,
    parameter int ID_W      = $clog2(REQS)
) (
    input logic           CLK,
    input logic           nRST,
    ram_arbiter_if.master bus
);

    localparam int              BW        = $clog2(MAX_BEATS) + 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0] TOP_ID    = ID_W'(REQS - 1);

    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [BW-1:0]   beats_q, beats_d;

    logic [REQS-1:0] req_any;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            own_ren, own_wen, release_now;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == TOP_ID) ? '0 : id + 1'b1;
    endfunction

    assign req_any = bus.req_ren | bus.req_wen;
    assign own_ren = bus.req_ren[owner_q];
    assign own_wen = bus.req_wen[owner_q];

    rr_picker #(.REQS(REQS), .ID_W(ID_W)) u_pick (
        .req_i   (req_any),
        .ptr_i   (rr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_d            = rr_q;
        beats_d         = beats_q;
        release_now     = 1'b0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        bus.req_wait    = '1;
        bus.req_load    = '0;
        bus.grant_valid = 1'b0;
        bus.grant_id    = '0;
        bus.ram_err     = 1'b0;

        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                owner_d = pick_idx;
                beats_d = '0;
                state_d = ARB_GRANT;
            end
        end else begin
            bus.ramaddr           = bus.req_addr[owner_q];
            bus.ramstore          = bus.req_store[owner_q];
            bus.ramWEN            = own_wen;
            bus.ramREN            = own_ren & ~own_wen;
            bus.grant_valid       = 1'b1;
            bus.grant_id          = owner_q;
            bus.req_load[owner_q] = bus.ramload;

            // A dropped request aborts silently, whatever the RAM reports.
            if (!own_ren && !own_wen) begin
                release_now = 1'b1;
            end else begin
                case (bus.ramstate)
                    ACCESS: begin
                        bus.req_wait[owner_q] = 1'b0;
                        if (bus.req_lock[owner_q] && (beats_q < LAST_BEAT))
                            beats_d = beats_q + BW'(1);
                        else
                            release_now = 1'b1;
                    end
                    ERROR: begin
                        bus.ram_err           = 1'b1;
                        bus.req_wait[owner_q] = 1'b0;
                        release_now           = 1'b1;
                    end
                    default: ;
                endcase
            end

            if (release_now) begin
                state_d = ARB_IDLE;
                rr_d    = wrap_inc(owner_q);
                beats_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset/rotation sequences and
// a randomized run against a transaction-level reference model.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int REQS      = 4;
    localparam int MAX_BEATS = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.REQS(REQS)) bus();

    ram_arbiter #(.REQS(REQS), .MAX_BEATS(MAX_BEATS)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] ren, wen, lock;
        word_t      a3;
        ramstate_t  rs;
        word_t      ld;
        logic       e_ren, e_wen;
        logic [3:0] e_wait;
        logic       e_gv;
        logic [1:0] e_gid;
        logic       e_err;
        word_t      e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] ren, logic [3:0] wen, logic [3:0] lock,
                                word_t a3, ramstate_t rs, word_t ld,
                                logic er, logic ew, logic [3:0] ewt, logic egv,
                                logic [1:0] egid, logic eerr, word_t eaddr);
        vec_t v;
        v.ren = ren; v.wen = wen; v.lock = lock; v.a3 = a3; v.rs = rs; v.ld = ld;
        v.e_ren = er; v.e_wen = ew; v.e_wait = ewt; v.e_gv = egv;
        v.e_gid = egid; v.e_err = eerr; v.e_addr = eaddr;
        return v;
    endfunction

    function automatic vec_t idle_row(logic [3:0] ren, logic [3:0] wen, logic [3:0] lock, word_t a3);
        return mk(ren, wen, lock, a3, FREE, 32'h0, 0, 0, 4'hF, 0, 2'd0, 0, 32'h0);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ctl_now();
        return {bus.ramREN, bus.ramWEN, bus.req_wait, bus.grant_valid, bus.grant_id, bus.ram_err};
    endfunction

    // Reference model: who owns the port, where rotation resumes, beats used.
    bit         m_busy;
    int         m_owner, m_ptr, m_beats;

    function automatic int model_pick(logic [3:0] req, int ptr);
        for (int k = 0; k < REQS; k++) begin
            if (req[(ptr + k) % REQS]) return (ptr + k) % REQS;
        end
        return 0;
    endfunction

    logic [3:0] r_ren, r_wen, r_lock;
    word_t      r_addr[REQS];
    word_t      r_store[REQS];

    initial begin
        vec_t       v;
        logic [127:0] eld;
        word_t      est;

        bus.req_ren = '0; bus.req_wen = '0; bus.req_lock = '0;
        bus.ramstate = FREE; bus.ramload = '0;
        bus.req_addr[0] = 32'h10; bus.req_addr[1] = 32'h40;
        bus.req_addr[2] = 32'h80; bus.req_addr[3] = 32'h100;
        for (int i = 0; i < REQS; i++) bus.req_store[i] = 32'hA000_0000 + i;

        #3;
        chk("reset ctl", ctl_now(), {1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0});
        chk("reset addr", bus.ramaddr, 32'h0);
        chk("reset load", bus.req_load, 128'h0);
        @(negedge clk);
        nrst = 1'b1;

        // Single read, locked write burst, write priority, error, aborts.
        tbl.push_back(idle_row(4'b0010, 4'b0, 4'b0, 32'h100));
        tbl.push_back(mk(4'b0010, 4'b0, 4'b0, 32'h100, BUSY, 32'h0, 1, 0, 4'hF, 1, 2'd1, 0, 32'h40));
        tbl.push_back(mk(4'b0010, 4'b0, 4'b0, 32'h100, BUSY, 32'h1111_1111, 1, 0, 4'hF, 1, 2'd1, 0, 32'h40));
        tbl.push_back(mk(4'b0010, 4'b0, 4'b0, 32'h100, ACCESS, 32'hDEAD_BEEF, 1, 0, 4'b1101, 1, 2'd1, 0, 32'h40));
        tbl.push_back(idle_row(4'b0, 4'b0, 4'b0, 32'h100));
        tbl.push_back(idle_row(4'b0001, 4'b1000, 4'b1000, 32'h100));
        tbl.push_back(mk(4'b0001, 4'b1000, 4'b1000, 32'h100, ACCESS, 32'h0, 0, 1, 4'b0111, 1, 2'd3, 0, 32'h100));
        tbl.push_back(mk(4'b0001, 4'b1000, 4'b1000, 32'h104, ACCESS, 32'h0, 0, 1, 4'b0111, 1, 2'd3, 0, 32'h104));
        tbl.push_back(idle_row(4'b0001, 4'b1000, 4'b1000, 32'h108));
        tbl.push_back(mk(4'b0001, 4'b1000, 4'b1000, 32'h108, ACCESS, 32'h1234_5678, 1, 0, 4'b1110, 1, 2'd0, 0, 32'h10));
        tbl.push_back(idle_row(4'b0, 4'b0, 4'b0, 32'h100));
        tbl.push_back(idle_row(4'b0100, 4'b0100, 4'b0, 32'h100));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0, 32'h100, BUSY, 32'h0, 0, 1, 4'hF, 1, 2'd2, 0, 32'h80));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0, 32'h100, ACCESS, 32'h0, 0, 1, 4'b1011, 1, 2'd2, 0, 32'h80));
        tbl.push_back(idle_row(4'b0, 4'b0, 4'b0, 32'h100));
        tbl.push_back(idle_row(4'b0001, 4'b0, 4'b0, 32'h100));
        tbl.push_back(mk(4'b0001, 4'b0, 4'b0, 32'h100, ERROR, 32'hCAFE_F00D, 1, 0, 4'b1110, 1, 2'd0, 1, 32'h10));
        tbl.push_back(idle_row(4'b0, 4'b0, 4'b0, 32'h100));
        tbl.push_back(idle_row(4'b0010, 4'b0, 4'b0, 32'h100));
        tbl.push_back(mk(4'b0010, 4'b0, 4'b0, 32'h100, BUSY, 32'h0, 1, 0, 4'hF, 1, 2'd1, 0, 32'h40));
        tbl.push_back(mk(4'b0000, 4'b0, 4'b0, 32'h100, BUSY, 32'h0, 0, 0, 4'hF, 1, 2'd1, 0, 32'h40));
        tbl.push_back(idle_row(4'b1110, 4'b0, 4'b0, 32'h100));
        tbl.push_back(mk(4'b1110, 4'b0, 4'b0, 32'h100, BUSY, 32'h0, 1, 0, 4'hF, 1, 2'd2, 0, 32'h80));
        tbl.push_back(mk(4'b0000, 4'b0, 4'b0, 32'h100, BUSY, 32'h0, 0, 0, 4'hF, 1, 2'd2, 0, 32'h80));
        tbl.push_back(idle_row(4'b0, 4'b0, 4'b0, 32'h100));

        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            @(negedge clk);
            bus.req_ren = v.ren; bus.req_wen = v.wen; bus.req_lock = v.lock;
            bus.req_addr[3] = v.a3; bus.ramstate = v.rs; bus.ramload = v.ld;
            #2;
            eld = '0;
            est = '0;
            if (v.e_gv) begin
                eld[v.e_gid*32 +: 32] = v.ld;
                est = 32'hA000_0000 + 32'(v.e_gid);
            end
            chk($sformatf("vec%0d ctl", k), ctl_now(),
                {v.e_ren, v.e_wen, v.e_wait, v.e_gv, v.e_gid, v.e_err});
            chk($sformatf("vec%0d addr", k), bus.ramaddr, v.e_addr);
            chk($sformatf("vec%0d store", k), bus.ramstore, est);
            chk($sformatf("vec%0d load", k), bus.req_load, eld);
        end

        // Asynchronous reset while requester 2 holds the port (rotation pointer is 3).
        @(negedge clk);
        bus.req_ren = 4'b0100; bus.ramstate = FREE;
        @(negedge clk);
        bus.ramstate = BUSY;
        #2;
        chk("pre-reset grant", {bus.ramREN, bus.grant_valid, bus.grant_id}, {1'b1, 1'b1, 2'd2});
        #1 nrst = 1'b0;
        #1;
        chk("async reset ctl", ctl_now(), {1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0});
        chk("async reset addr", bus.ramaddr, 32'h0);

        // All four read continuously, ACCESS on every grant cycle.
        @(negedge clk);
        bus.req_ren = 4'hF;
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            bus.ramstate = (i % 2 == 1) ? ACCESS : FREE;
            #2;
            if (i % 2 == 1)
                chk($sformatf("rotation %0d", i / 2), {bus.grant_valid, bus.grant_id},
                    {1'b1, 2'((i / 2) % REQS)});
            else
                chk($sformatf("rotation bubble %0d", i / 2), bus.grant_valid, 1'b0);
        end

        // Randomized run against the reference model.
        @(negedge clk);
        bus.req_ren = '0; bus.req_wen = '0; bus.req_lock = '0; bus.ramstate = FREE;
        nrst = 1'b0;
        #2 nrst = 1'b1;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
        r_ren = '0; r_wen = '0; r_lock = '0;
        for (int n = 0; n < 500; n++) begin
            logic       e_ren, e_wen, e_gv, e_err, rel;
            logic [3:0] e_wait;
            logic [1:0] e_gid;
            word_t      e_addr, e_st, ld;
            logic [127:0] e_ld;
            ramstate_t  rs;
            int         o;

            @(negedge clk);
            for (int i = 0; i < REQS; i++) begin
                if ($urandom_range(0, 3) == 0) r_ren[i] = ~r_ren[i];
                if ($urandom_range(0, 7) == 0) r_wen[i] = ~r_wen[i];
                r_lock[i]  = 1'($urandom_range(0, 1));
                r_addr[i]  = $urandom;
                r_store[i] = $urandom;
                bus.req_addr[i]  = r_addr[i];
                bus.req_store[i] = r_store[i];
            end
            rs = ramstate_t'($urandom_range(0, 3));
            ld = $urandom;
            bus.req_ren = r_ren; bus.req_wen = r_wen; bus.req_lock = r_lock;
            bus.ramstate = rs; bus.ramload = ld;

            e_ren = 0; e_wen = 0; e_gv = 0; e_err = 0; e_wait = 4'hF; e_gid = 0;
            e_addr = 0; e_st = 0; e_ld = '0; rel = 0;
            if (m_busy) begin
                o = m_owner;
                e_gv = 1; e_gid = 2'(o);
                e_addr = r_addr[o]; e_st = r_store[o];
                e_wen = r_wen[o]; e_ren = r_ren[o] && !r_wen[o];
                e_ld[o*32 +: 32] = ld;
                if (!(r_ren[o] || r_wen[o])) rel = 1;
                else if (rs == ACCESS) begin
                    e_wait[o] = 1'b0;
                    if (r_lock[o] && (m_beats + 1 < MAX_BEATS)) m_beats++;
                    else rel = 1;
                end else if (rs == ERROR) begin
                    e_err = 1; e_wait[o] = 1'b0; rel = 1;
                end
                if (rel) begin
                    m_busy = 0; m_ptr = (o + 1) % REQS; m_beats = 0;
                end
            end else if ((r_ren | r_wen) != 4'b0) begin
                m_owner = model_pick(r_ren | r_wen, m_ptr);
                m_busy = 1; m_beats = 0;
            end

            #2;
            chk($sformatf("rnd%0d ctl", n), ctl_now(), {e_ren, e_wen, e_wait, e_gv, e_gid, e_err});
            chk($sformatf("rnd%0d addr", n), bus.ramaddr, e_addr);
            chk($sformatf("rnd%0d store", n), bus.ramstore, e_st);
            chk($sformatf("rnd%0d load", n), bus.req_load, e_ld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
